// File: rtl/errchk_pkg.sv
// errchk_pkg: state encoding, question LFSR taps and the expected-answer function
// shared by the challenge/response health-check scheduler.
package errchk_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_INT = 3'd1,
      ISSUE    = 3'd2,
      WAIT_ANS = 3'd3,
      EVAL     = 3'd4,
      SHUTDOWN = 3'd5
   } errchk_state_e;

   // Fibonacci x^4+x^3+1: feedback bit is value[3]^value[2]
   localparam logic [3:0] LFSR_TAPS = 4'b1100;

   function automatic logic [3:0] local_answer(input logic [3:0] q);
      return {q[2] ^ q[3], q[1] ^ q[2], q[0] ^ q[1], ~q[0]};
   endfunction

endpackage

// File: rtl/question_lfsr.sv
// question_lfsr: 4-bit maximal-length question generator; steps once per advance pulse.
// A zero seed is replaced by 4'h1 so the register can never lock up at zero.
module question_lfsr
   import errchk_pkg::*;
#(
   parameter logic [3:0] SEED = 4'h9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       advance,
   output logic [3:0] value
);

   localparam logic [3:0] START = (SEED == 4'h0) ? 4'h1 : SEED;

   logic [3:0] value_r;

   // Shift register stepping on each issued question
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_r <= START;
      end else if (advance) begin
         value_r <= {value_r[2:0], ^(value_r & LFSR_TAPS)};
      end else begin
         value_r <= value_r;
      end
   end

   assign value = value_r;

endmodule

// File: rtl/challenge_scheduler.sv
// challenge_scheduler: issues timed challenges to OBC1, scores rounds and forces failover to OBC2.
// Build option ERRCHK_STATS_EN adds saturating total_pass/total_fail answer counters.
module challenge_scheduler
   import errchk_pkg::*;
#(
   parameter int unsigned ROUND_LEN   = 10,
   parameter int unsigned PASS_MIN    = 7,
   parameter int unsigned MAX_STRIKES = 3,
   parameter int unsigned INTERVAL    = 1000,
   parameter int unsigned TIMEOUT     = 255,
   parameter logic [3:0]  LFSR_SEED   = 4'h9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [3:0]  question,
   output logic        q_valid,
   input  logic [3:0]  answerOBC,
   input  logic        a_valid,
   output logic        healthy,
   output logic [3:0]  strikes,
   output logic        override,
   output logic        shutdown_obc1,
   output logic [2:0]  state_o
`ifdef ERRCHK_STATS_EN
   ,
   output logic [15:0] total_pass,
   output logic [15:0] total_fail
`endif
);

   localparam logic [15:0] INT_LAST   = 16'(INTERVAL - 1);
   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
   localparam logic [8:0]  RND_LEN    = 9'(ROUND_LEN);
   localparam logic [7:0]  RND_FULL   = 8'(ROUND_LEN);
   localparam logic [7:0]  PASS_LIM   = 8'(PASS_MIN);
   localparam logic [3:0]  STRIKE_LIM = 4'(MAX_STRIKES);

   errchk_state_e state_r, state_nxt_s;
   logic [15:0]   int_cnt_r, to_cnt_r;
   logic [7:0]    issued_r, correct_r;
   logic [3:0]    question_r, strikes_r, strikes_nxt_s, lfsr_value_s;
   logic          q_valid_r, healthy_r, healthy_nxt_s, override_r;
   logic          issue_s, eval_s, ans_done_s, ans_ok_s;

   question_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .advance (issue_s),
      .value   (lfsr_value_s)
   );

   // Next-state decode; a late answer wins over a simultaneous timeout
   always_comb begin
      state_nxt_s   = state_r;
      strikes_nxt_s = strikes_r;
      healthy_nxt_s = healthy_r;
      issue_s       = 1'b0;
      eval_s        = 1'b0;
      ans_done_s    = 1'b0;
      ans_ok_s      = 1'b0;
      if (state_r == SHUTDOWN) begin
         state_nxt_s = SHUTDOWN;
      end else if (!enable) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:     state_nxt_s = WAIT_INT;
            WAIT_INT: state_nxt_s = (int_cnt_r == INT_LAST) ? ISSUE : WAIT_INT;
            ISSUE: begin
               issue_s     = 1'b1;
               state_nxt_s = WAIT_ANS;
            end
            WAIT_ANS: begin
               if (a_valid || (to_cnt_r == TO_LAST)) begin
                  ans_done_s  = 1'b1;
                  ans_ok_s    = a_valid && (answerOBC == local_answer(question_r));
                  state_nxt_s = (({1'b0, issued_r} + 9'd1) >= RND_LEN) ? EVAL : WAIT_INT;
               end else begin
                  state_nxt_s = WAIT_ANS;
               end
            end
            EVAL: begin
               eval_s = 1'b1;
               if (correct_r == RND_FULL) begin
                  strikes_nxt_s = 4'd0;
               end else if (correct_r >= PASS_LIM) begin
                  strikes_nxt_s = strikes_r;
               end else if (strikes_r == 4'hF) begin
                  strikes_nxt_s = 4'hF;
               end else begin
                  strikes_nxt_s = strikes_r + 4'd1;
               end
               healthy_nxt_s = (correct_r >= PASS_LIM);
               state_nxt_s   = (strikes_nxt_s >= STRIKE_LIM) ? SHUTDOWN : WAIT_INT;
            end
            default:  state_nxt_s = IDLE;
         endcase
      end
   end

   // State, timers, round scoring and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         int_cnt_r  <= 16'd0;
         to_cnt_r   <= 16'd0;
         issued_r   <= 8'd0;
         correct_r  <= 8'd0;
         question_r <= 4'd0;
         q_valid_r  <= 1'b0;
         healthy_r  <= 1'b0;
         strikes_r  <= 4'd0;
         override_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         int_cnt_r  <= ((state_r == WAIT_INT) && (state_nxt_s == WAIT_INT)) ? int_cnt_r + 16'd1 : 16'd0;
         to_cnt_r   <= ((state_r == WAIT_ANS) && (state_nxt_s == WAIT_ANS)) ? to_cnt_r + 16'd1 : 16'd0;
         q_valid_r  <= issue_s;
         question_r <= issue_s ? lfsr_value_s : question_r;
         override_r <= override_r | (state_nxt_s == SHUTDOWN);
         if (eval_s) begin
            issued_r  <= 8'd0;
            correct_r <= 8'd0;
            strikes_r <= strikes_nxt_s;
            healthy_r <= healthy_nxt_s;
         end else if (ans_done_s) begin
            issued_r  <= issued_r + 8'd1;
            correct_r <= correct_r + {7'd0, ans_ok_s};
         end else begin
            issued_r  <= issued_r;
            correct_r <= correct_r;
         end
      end
   end

`ifdef ERRCHK_STATS_EN
   logic [15:0] pass_r, fail_r;

   // Lifetime answer statistics; survive enable drops, saturate at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pass_r <= 16'd0;
         fail_r <= 16'd0;
      end else if (ans_done_s && ans_ok_s) begin
         pass_r <= (pass_r == 16'hFFFF) ? pass_r : pass_r + 16'd1;
      end else if (ans_done_s) begin
         fail_r <= (fail_r == 16'hFFFF) ? fail_r : fail_r + 16'd1;
      end else begin
         pass_r <= pass_r;
         fail_r <= fail_r;
      end
   end

   assign total_pass = pass_r;
   assign total_fail = fail_r;
`endif

   assign question      = question_r;
   assign q_valid       = q_valid_r;
   assign healthy       = healthy_r;
   assign strikes       = strikes_r;
   assign override      = override_r;
   assign shutdown_obc1 = override_r;
   assign state_o       = state_r;

endmodule

// File: tb/tb_challenge_scheduler.sv
// tb_challenge_scheduler: round-table driven bench for challenge_scheduler with question and
// round-result scoreboards; ERRCHK_STATS_EN also enables the statistics checks.
module tb_challenge_scheduler;

   localparam logic [2:0] S_IDLE = 3'd0, S_WAIT_INT = 3'd1, S_WAIT_ANS = 3'd3;
   localparam logic [2:0] S_EVAL = 3'd4, S_SHUTDOWN = 3'd5;
   localparam logic [1:0] M_CORR = 2'd0, M_WRONG = 2'd1, M_NONE = 2'd2, M_COINC = 2'd3;
   localparam int NUM_ROUNDS = 7;

   typedef struct packed {
      logic [2:0][1:0] mode;
      logic            stray;
      logic            exp_healthy;
      logic [3:0]      exp_strikes;
      logic            exp_shut;
   } round_vec_t;

   typedef struct packed {
      logic       healthy;
      logic [3:0] strikes;
      logic       shut;
   } round_res_t;

   logic       clk = 1'b0;
   logic       reset, enable, a_valid;
   logic [3:0] answer_obc, question, strikes;
   logic       q_valid, healthy, override, shutdown_obc1;
   logic [2:0] state_o;
`ifdef ERRCHK_STATS_EN
   logic [15:0] total_pass, total_fail;
`endif

   int checks = 0;
   int failures = 0;
   int exp_pass = 0;
   int exp_fail = 0;
   logic [3:0] model_lfsr = 4'h9;
   logic       prev_healthy = 1'b0;
   logic [3:0] prev_strikes = 4'd0;
   logic [3:0] q_exp_question[$];
   round_res_t q_exp_round[$];
   round_vec_t rounds[NUM_ROUNDS];

   challenge_scheduler #(
      .ROUND_LEN(3), .PASS_MIN(2), .MAX_STRIKES(2), .INTERVAL(4), .TIMEOUT(8), .LFSR_SEED(4'h9)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .question      (question),
      .q_valid       (q_valid),
      .answerOBC     (answer_obc),
      .a_valid       (a_valid),
      .healthy       (healthy),
      .strikes       (strikes),
      .override      (override),
      .shutdown_obc1 (shutdown_obc1),
      .state_o       (state_o)
`ifdef ERRCHK_STATS_EN
      ,
      .total_pass    (total_pass),
      .total_fail    (total_fail)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_answer(input logic [3:0] q);
      return {q[2] ^ q[3], q[1] ^ q[2], q[0] ^ q[1], ~q[0]};
   endfunction

   function automatic logic [3:0] ref_next(input logic [3:0] v);
      return {v[2:0], v[3] ^ v[2]};
   endfunction

   function automatic round_vec_t mk_round(input logic [1:0] m0, m1, m2, input logic stray,
                                           input logic h, input logic [3:0] s, input logic sh);
      round_vec_t r;
      r.mode[0] = m0; r.mode[1] = m1; r.mode[2] = m2;
      r.stray = stray; r.exp_healthy = h; r.exp_strikes = s; r.exp_shut = sh;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Wait (bounded) for q_valid; optionally pulse a stray a_valid while in WAIT_INT
   task automatic wait_qvalid(input bit stray, output int n, output bit found);
      n = 0;
      found = 1'b0;
      while (n < 40 && !found) begin
         if (q_valid) begin
            found = 1'b1;
         end else begin
            a_valid    = stray && (n == 1 || n == 2);
            answer_obc = ref_answer(model_lfsr);
            @(negedge clk);
            n++;
         end
      end
      a_valid = 1'b0;
   endtask

   task automatic issue_and_check(input bit stray, output logic [3:0] exp_q);
      int  n;
      bit  found;
      q_exp_question.push_back(model_lfsr);
      wait_qvalid(stray, n, found);
      check("q_valid_seen", {31'd0, found}, 32'd1);
      check("q_latency", n, 32'd5);
      exp_q = q_exp_question.pop_front();
      check("question", {28'd0, question}, {28'd0, exp_q});
      model_lfsr = ref_next(model_lfsr);
   endtask

   task automatic do_challenge(input logic [1:0] mode, input bit stray, input bit last);
      logic [3:0] exp_q;
      int cyc, drive_at, exp_len;
      issue_and_check(stray, exp_q);
      drive_at = (mode == M_CORR || mode == M_WRONG) ? 2 : (mode == M_COINC) ? 7 : -1;
      exp_len  = (mode == M_CORR || mode == M_WRONG) ? 3 : 8;
      if (mode == M_CORR || mode == M_COINC) exp_pass++;
      else exp_fail++;
      cyc = 0;
      while (state_o == S_WAIT_ANS && cyc < 20) begin
         a_valid    = (cyc == drive_at);
         answer_obc = (mode == M_WRONG) ? (ref_answer(exp_q) ^ 4'h5) : ref_answer(exp_q);
         @(negedge clk);
         cyc++;
      end
      a_valid = 1'b0;
      check("wait_ans_len", cyc, exp_len);
      check("post_answer_state", {29'd0, state_o}, last ? {29'd0, S_EVAL} : {29'd0, S_WAIT_INT});
   endtask

   task automatic run_round(input round_vec_t v);
      round_res_t r;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) q_exp_round.push_back({v.exp_healthy, v.exp_strikes, v.exp_shut});
         do_challenge(v.mode[i], v.stray, i == 2);
      end
      check("eval_healthy_hold", {31'd0, healthy}, {31'd0, prev_healthy});
      check("eval_strikes_hold", {28'd0, strikes}, {28'd0, prev_strikes});
      @(negedge clk);
      r = q_exp_round.pop_front();
      check("healthy", {31'd0, healthy}, {31'd0, r.healthy});
      check("strikes", {28'd0, strikes}, {28'd0, r.strikes});
      check("override", {31'd0, override}, {31'd0, r.shut});
      check("shutdown_obc1", {31'd0, shutdown_obc1}, {31'd0, r.shut});
      check("eval_exit_state", {29'd0, state_o}, r.shut ? {29'd0, S_SHUTDOWN} : {29'd0, S_WAIT_INT});
      prev_healthy = r.healthy;
      prev_strikes = r.strikes;
   endtask

   // Drop enable two cycles into WAIT_ANS, then resume
   task automatic abort_round();
      logic [3:0] exp_q;
      issue_and_check(1'b0, exp_q);
      repeat (2) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("abort_state", {29'd0, state_o}, {29'd0, S_IDLE});
      check("abort_strikes", {28'd0, strikes}, {28'd0, prev_strikes});
      check("abort_healthy", {31'd0, healthy}, {31'd0, prev_healthy});
      repeat (3) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      check("resume_state", {29'd0, state_o}, {29'd0, S_WAIT_INT});
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_question"}, {28'd0, question}, 32'd0);
      check({tag, "_q_valid"}, {31'd0, q_valid}, 32'd0);
      check({tag, "_healthy"}, {31'd0, healthy}, 32'd0);
      check({tag, "_strikes"}, {28'd0, strikes}, 32'd0);
      check({tag, "_override"}, {31'd0, override}, 32'd0);
      check({tag, "_shutdown"}, {31'd0, shutdown_obc1}, 32'd0);
      check({tag, "_state"}, {29'd0, state_o}, {29'd0, S_IDLE});
`ifdef ERRCHK_STATS_EN
      check({tag, "_total_pass"}, {16'd0, total_pass}, 32'd0);
      check({tag, "_total_fail"}, {16'd0, total_fail}, 32'd0);
`endif
   endtask

   initial begin
      rounds[0] = mk_round(M_CORR, M_CORR, M_CORR, 1'b0, 1'b1, 4'd0, 1'b0);
      rounds[1] = mk_round(M_NONE, M_NONE, M_NONE, 1'b0, 1'b0, 4'd1, 1'b0);
      rounds[2] = mk_round(M_CORR, M_CORR, M_WRONG, 1'b0, 1'b1, 4'd1, 1'b0);
      rounds[3] = mk_round(M_CORR, M_CORR, M_CORR, 1'b0, 1'b1, 4'd0, 1'b0);
      rounds[4] = mk_round(M_NONE, M_COINC, M_CORR, 1'b1, 1'b1, 4'd0, 1'b0);
      rounds[5] = mk_round(M_NONE, M_NONE, M_NONE, 1'b0, 1'b0, 4'd1, 1'b0);
      rounds[6] = mk_round(M_NONE, M_NONE, M_NONE, 1'b0, 1'b0, 4'd2, 1'b1);

      reset = 1'b0; enable = 1'b0; a_valid = 1'b0; answer_obc = 4'd0;
      repeat (2) @(negedge clk);
      check_outputs_reset("reset");
      reset = 1'b1;
      @(negedge clk);
      check("idle_disabled", {29'd0, state_o}, {29'd0, S_IDLE});
      enable = 1'b1;
      @(negedge clk);
      check("enter_wait_int", {29'd0, state_o}, {29'd0, S_WAIT_INT});

      for (int r = 0; r < NUM_ROUNDS; r++) begin
         if (r == 2) abort_round();
         run_round(rounds[r]);
`ifdef ERRCHK_STATS_EN
         if (r == 0) begin
            check("stats_pass_r0", {16'd0, total_pass}, 32'd3);
            check("stats_fail_r0", {16'd0, total_fail}, 32'd0);
         end
`endif
      end

`ifdef ERRCHK_STATS_EN
      check("stats_pass_end", {16'd0, total_pass}, exp_pass);
      check("stats_fail_end", {16'd0, total_fail}, exp_fail);
`endif
      for (int i = 0; i < 4; i++) begin
         enable = ~enable;
         @(negedge clk);
         check("sticky_state", {29'd0, state_o}, {29'd0, S_SHUTDOWN});
         check("sticky_override", {31'd0, override}, 32'd1);
         check("sticky_shutdown", {31'd0, shutdown_obc1}, 32'd1);
      end

      enable = 1'b1;
      #2 reset = 1'b0;
      #1 check_outputs_reset("async_reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("restart_state", {29'd0, state_o}, {29'd0, S_WAIT_INT});
      model_lfsr = 4'h9;
      do_challenge(M_CORR, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
